// File: rtl/rx_burst_if.sv
// Payload symbol handshake between rx_burst (master) and the burst deframer (slave).
interface rx_burst_if;
  logic burst_bit;
  logic burst_bit_valid;
  logic burst_bit_ready;

  modport master (output burst_bit, output burst_bit_valid, input burst_bit_ready);
  modport slave  (input burst_bit, input burst_bit_valid, output burst_bit_ready);
endinterface

// File: rtl/rx_burst.sv
// Receive burst controller: energy hunt, TSC sync search, payload delivery via a 4-deep buffer.
// Define RX_RSSI_EN to build the per-burst RSSI accumulator; otherwise burst_rssi is tied to 0.
module rx_burst #(
  parameter int                 SAMPLE_BITS     = 8,
  parameter int                 POWER_THRESH    = 64,
  parameter int                 POWER_HOLD      = 4,
  parameter int                 TSC_LEN         = 26,
  parameter logic [TSC_LEN-1:0] TSC_PATTERN     = 26'h0970897,
  parameter int                 SYNC_ERR_MAX    = 2,
  parameter int                 SEARCH_WINDOW   = 64,
  parameter int                 PAYLOAD_SYMBOLS = 116,
  parameter int                 RSSI_BITS       = 20
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic signed [SAMPLE_BITS-1:0] rfchain_inphase,
  input  logic signed [SAMPLE_BITS-1:0] rfchain_quadrature,
  input  logic                          rfchain_rx_valid,
  input  logic                          demod_symbol,
  input  logic                          demod_symbol_strobe,
  input  logic                          arm_burst,
  input  logic                          abort_burst,
  output logic                          is_armed,
  output logic                          sync_found,
  rx_burst_if.master                    burst,
  output logic                          burst_done,
  output logic                          burst_error,
  output logic [RSSI_BITS-1:0]          burst_rssi
);
  localparam int MAG_W   = SAMPLE_BITS + 1;
  localparam int CNT_MAX = (SEARCH_WINDOW > PAYLOAD_SYMBOLS) ? SEARCH_WINDOW : PAYLOAD_SYMBOLS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HOLD_W  = $clog2(POWER_HOLD + 1);
  localparam int ERR_W   = $clog2(TSC_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_HUNT, S_SYNC, S_DELIVER, S_DRAIN} state_t;

  // |x| with the most negative code clamped to the largest positive code
  function automatic logic [SAMPLE_BITS-1:0] abs_sat(input logic signed [SAMPLE_BITS-1:0] x);
    logic [SAMPLE_BITS-1:0] r;
    if (x == {1'b1, {(SAMPLE_BITS-1){1'b0}}}) r = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
    else if (x < 0)                           r = $unsigned(-x);
    else                                      r = $unsigned(x);
    return r;
  endfunction

  function automatic logic [ERR_W-1:0] popcount(input logic [TSC_LEN-1:0] v);
    logic [ERR_W-1:0] n;
    n = '0;
    for (int k = 0; k < TSC_LEN; k++) n = n + ERR_W'(v[k]);
    return n;
  endfunction

  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]   sym_cnt;
  logic [TSC_LEN-1:0] sr;
  logic [3:0]         fifo_mem;
  logic [1:0]         wr_ptr, rd_ptr;
  logic [2:0]         fifo_cnt;
  logic [MAG_W-1:0]   mag;
  logic               energetic, push_req, push, pop, full, empty;
  logic               sync_hit, timeout, overflow, done_now, flush;

  assign mag       = MAG_W'(abs_sat(rfchain_inphase)) + MAG_W'(abs_sat(rfchain_quadrature));
  assign energetic = (mag >= MAG_W'(POWER_THRESH));
  assign empty     = (fifo_cnt == 3'd0);
  assign full      = (fifo_cnt == 3'd4);
  assign pop       = !empty && burst.burst_bit_ready;
  assign push      = push_req && (!full || pop);
  assign overflow  = push_req && full && !pop;
  assign is_armed  = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    sync_hit  = 1'b0;
    timeout   = 1'b0;
    done_now  = 1'b0;
    flush     = 1'b0;
    case (state)
      S_IDLE:    if (arm_burst && !abort_burst) state_nxt = S_HUNT;
      S_HUNT:    if (hold_cnt == HOLD_W'(POWER_HOLD)) state_nxt = S_SYNC;
      // Decision uses the registered shift register, one cycle after the strobe
      S_SYNC:    if (!demod_symbol_strobe && sym_cnt >= CNT_W'(TSC_LEN)) begin
                   if (popcount(sr ^ TSC_PATTERN) <= ERR_W'(SYNC_ERR_MAX)) begin
                     sync_hit  = 1'b1;
                     state_nxt = S_DELIVER;
                   end else if (sym_cnt == CNT_W'(SEARCH_WINDOW)) begin
                     timeout   = 1'b1;
                     state_nxt = S_IDLE;
                   end
                 end
      S_DELIVER: if (demod_symbol_strobe) begin
                   push_req = 1'b1;
                   if (sym_cnt == CNT_W'(PAYLOAD_SYMBOLS - 1)) state_nxt = S_DRAIN;
                 end
      S_DRAIN:   if (empty) begin
                   done_now  = 1'b1;
                   state_nxt = S_IDLE;
                 end
      default:   state_nxt = S_IDLE;
    endcase
    if (abort_burst && state != S_IDLE) begin
      state_nxt = S_IDLE;
      flush     = 1'b1;
      push_req  = 1'b0;
      sync_hit  = 1'b0;
      timeout   = 1'b0;
      done_now  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // sym_cnt counts search symbols in SYNC, then restarts to count payload pushes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      sym_cnt  <= '0;
    end else if (state == S_IDLE) begin
      hold_cnt <= '0;
      sym_cnt  <= '0;
    end else begin
      if (state == S_HUNT && rfchain_rx_valid && hold_cnt != HOLD_W'(POWER_HOLD))
        hold_cnt <= energetic ? hold_cnt + HOLD_W'(1) : '0;
      if (sync_hit)
        sym_cnt <= '0;
      else if ((state == S_SYNC || state == S_DELIVER) && demod_symbol_strobe)
        sym_cnt <= sym_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (state == S_SYNC && demod_symbol_strobe) sr <= {sr[TSC_LEN-2:0], demod_symbol};
    if (push) fifo_mem[wr_ptr] <= demod_symbol;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
    end
  end

  assign burst.burst_bit_valid = !empty;
  assign burst.burst_bit       = !empty && fifo_mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_found  <= 1'b0;
      burst_error <= 1'b0;
      burst_done  <= 1'b0;
    end else begin
      sync_found  <= sync_hit;
      burst_error <= timeout || overflow;
      burst_done  <= done_now;
    end
  end

`ifdef RX_RSSI_EN
  function automatic logic [RSSI_BITS-1:0] sat_add(input logic [RSSI_BITS-1:0] a,
                                                   input logic [MAG_W-1:0] b);
    logic [RSSI_BITS:0] s;
    s = {1'b0, a} + (RSSI_BITS+1)'(b);
    return s[RSSI_BITS] ? {RSSI_BITS{1'b1}} : s[RSSI_BITS-1:0];
  endfunction

  logic [RSSI_BITS-1:0] rssi_acc;

  always_ff @(posedge clock) begin
    if (state == S_HUNT && state_nxt == S_SYNC)
      rssi_acc <= '0;
    else if ((state == S_SYNC || state == S_DELIVER || state == S_DRAIN) && rfchain_rx_valid)
      rssi_acc <= sat_add(rssi_acc, mag);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      burst_rssi <= '0;
    else if (done_now) burst_rssi <= rssi_acc;
  end
`else
  assign burst_rssi = '0;
`endif
endmodule
